// File: rtl/csa_arbiter.sv
// Two-requester arbiter sharing one 32-bit carry-select adder; res_ovf exists only
// when CSA_ARB_OVF_EN is defined.

// Purpose: 32-bit carry-select adder built from four 8-bit blocks.
// Latency: combinational.
// Backpressure: none.
module csa_add32 (
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   input  logic        i_cin,
   output logic [31:0] o_sum,
   output logic        o_cout
);
   localparam int BW = 8;
   localparam int NB = 4;

   logic [NB:0] w_c;

   assign w_c[0] = i_cin;

   for (genvar g = 0; g < NB; g++) begin : g_blk
      logic [BW:0] w_s0;
      logic [BW:0] w_s1;
      // Both carry-in outcomes are ready before the block's carry arrives.
      assign w_s0 = {1'b0, i_a[g*BW +: BW]} + {1'b0, i_b[g*BW +: BW]};
      assign w_s1 = w_s0 + (BW+1)'(1);
      assign o_sum[g*BW +: BW] = w_c[g] ? w_s1[BW-1:0] : w_s0[BW-1:0];
      assign w_c[g+1]          = w_c[g] ? w_s1[BW]     : w_s0[BW];
   end

   assign o_cout = w_c[NB];
endmodule

// Purpose: grants one of two operand requesters, adds on the shared adder, holds the result.
// Latency: accept at cycle N gives res_valid at N+2; one result per 2 cycles at best.
// Backpressure: readys are low in CALC and in RESULT until res_ready; the result holds until taken.
module csa_arbiter #(
   parameter int PRIO_FIX = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   input  logic        req1_valid,
   output logic        req0_ready,
   output logic        req1_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_cin,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_cin,
   output logic        res_valid,
   input  logic        res_ready,
   output logic [31:0] res_sum,
   output logic        res_cout,
   output logic        res_id
`ifdef CSA_ARB_OVF_EN
   ,
   output logic        res_ovf
`endif
);
   typedef enum logic [1:0] {IDLE, CALC, RESULT} state_t;

   state_t      r_state;
   state_t      w_state_nxt;
   logic        r_last;
   logic [31:0] r_a;
   logic [31:0] r_b;
   logic        r_cin;
   logic        r_op_id;
   logic        w_any;
   logic        w_win;
   logic        w_accept;
   logic        w_take;
   logic [31:0] w_sum;
   logic        w_cout;

   assign w_any = req0_valid | req1_valid;

   // r_last resets to 1 so requester 0 wins the first tie.
   always_comb begin
      w_win = ~req0_valid;
      if (PRIO_FIX == 0 && req0_valid && req1_valid) begin
         w_win = ~r_last;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_any) begin
               w_accept    = 1'b1;
               w_state_nxt = CALC;
            end
         end
         CALC: begin
            w_state_nxt = RESULT;
         end
         RESULT: begin
            if (res_ready) begin
               w_accept    = w_any;
               w_state_nxt = w_any ? CALC : IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
      req0_ready = w_accept & ~w_win & rst_n;
      req1_ready = w_accept &  w_win & rst_n;
   end

   assign w_take    = req0_ready | req1_ready;
   assign res_valid = (r_state == RESULT);

   csa_add32 u_add (
      .i_a    (r_a),
      .i_b    (r_b),
      .i_cin  (r_cin),
      .o_sum  (w_sum),
      .o_cout (w_cout)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last  <= 1'b1;
         r_a     <= '0;
         r_b     <= '0;
         r_cin   <= 1'b0;
         r_op_id <= 1'b0;
      end else if (w_take) begin
         r_last  <= w_win;
         r_a     <= w_win ? req1_a   : req0_a;
         r_b     <= w_win ? req1_b   : req0_b;
         r_cin   <= w_win ? req1_cin : req0_cin;
         r_op_id <= w_win;
      end
   end

   // Result registers load only in CALC, so a back-to-back accept cannot disturb them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_sum  <= '0;
         res_cout <= 1'b0;
         res_id   <= 1'b0;
      end else if (r_state == CALC) begin
         res_sum  <= w_sum;
         res_cout <= w_cout;
         res_id   <= r_op_id;
      end
   end

`ifdef CSA_ARB_OVF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_ovf <= 1'b0;
      end else if (r_state == CALC) begin
         res_ovf <= (r_a[31] == r_b[31]) && (w_sum[31] != r_a[31]);
      end
   end
`endif
endmodule

// File: tb/tb_csa_arbiter.sv
// Bench for csa_arbiter: directed cases, then random traffic against a
// transaction-level model feeding a scoreboard; a PRIO_FIX=1 copy runs alongside.
module tb_csa_arbiter;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        req0_valid, req1_valid, req0_ready, req1_ready;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        req0_cin, req1_cin;
   logic        res_valid, res_ready, res_cout, res_id, res_ovf;
   logic [31:0] res_sum;
   logic        fx_r0, fx_r1, fx_rv, fx_cout, fx_id, fx_ovf;
   logic [31:0] fx_sum;

   always #5 clk = ~clk;

   csa_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_cin(req0_cin),
      .req1_a(req1_a), .req1_b(req1_b), .req1_cin(req1_cin),
      .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
      .res_cout(res_cout), .res_id(res_id)
`ifdef CSA_ARB_OVF_EN
      , .res_ovf(res_ovf)
`endif
   );

   csa_arbiter #(.PRIO_FIX(1)) dut_fix (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(1'b1), .req1_valid(1'b1),
      .req0_ready(fx_r0), .req1_ready(fx_r1),
      .req0_a(32'd5), .req0_b(32'd6), .req0_cin(1'b0),
      .req1_a(32'd7), .req1_b(32'd8), .req1_cin(1'b1),
      .res_valid(fx_rv), .res_ready(1'b1), .res_sum(fx_sum),
      .res_cout(fx_cout), .res_id(fx_id)
`ifdef CSA_ARB_OVF_EN
      , .res_ovf(fx_ovf)
`endif
   );

`ifndef CSA_ARB_OVF_EN
   assign res_ovf = 1'b0;
   assign fx_ovf  = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        id;
      logic        ovf;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_c = 0;
   int   fx_n = 0;
   bit   last_g = 1'b1;
   bit   pend = 1'b0;
   bit   hs0 = 1'b0;
   bit   hs1 = 1'b0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
      end
   endtask

   function automatic exp_t ref_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic cin, input logic id);
      exp_t        r;
      logic [32:0] full;
      full  = {1'b0, a} + {1'b0, b} + 33'(cin);
      r.sum  = full[31:0];
      r.cout = full[32];
      r.id   = id;
      r.ovf  = (a[31] == b[31]) && (full[31] != a[31]);
      return r;
   endfunction

   function automatic logic [31:0] rnd();
      case ($urandom_range(0, 5))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h0000_0001;
         default: return $urandom;
      endcase
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // Transaction model: one operation in flight, result visible two cycles after
   // acceptance, a new accept allowed when idle or when the result is being taken.
   always @(negedge clk) begin
      bit exp_rv, dlv, can, w, er0, er1;
      if (!rst_n) begin
         pend   = 1'b0;
         last_g = 1'b1;
         hs0    = 1'b0;
         hs1    = 1'b0;
         sb.delete();
         chk("reset_outputs", {res_valid, req0_ready, req1_ready, res_cout, res_id,
                               res_ovf, res_sum}, 64'd0);
      end else begin
         exp_rv = pend && (cyc >= acc_c + 2);
         dlv    = exp_rv && res_ready;
         can    = !pend || dlv;
         w      = (req0_valid && req1_valid) ? !last_g : !req0_valid;
         er0    = can && req0_valid && !w;
         er1    = can && req1_valid && w;
         chk("valid_ready0_ready1", {res_valid, req0_ready, req1_ready}, {exp_rv, er0, er1});
         hs0 = req0_valid && req0_ready;
         hs1 = req1_valid && req1_ready;
         if (dlv) pend = 1'b0;
         if (er0 || er1) begin
            sb.push_back(w ? ref_op(req1_a, req1_b, req1_cin, 1'b1)
                           : ref_op(req0_a, req0_b, req0_cin, 1'b0));
            pend   = 1'b1;
            acc_c  = cyc;
            last_g = w;
         end
      end
   end

   // Monitor: result must match the scoreboard head on every cycle it is shown.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n && res_valid) begin
         if (sb.size() == 0) begin
            chk("result_expected", 64'd0, 64'd1);
         end else begin
            e = sb[0];
            chk("res_sum", res_sum, e.sum);
            chk("res_cout_id", {res_cout, res_id}, {e.cout, e.id});
`ifdef CSA_ARB_OVF_EN
            chk("res_ovf", res_ovf, e.ovf);
`endif
            if (res_ready) void'(sb.pop_front());
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n) begin
         chk("fixprio_grant", {fx_r1, fx_rv && fx_id}, 64'd0);
         if (fx_r0) fx_n++;
      end
   end

   task automatic wait_hs();
      bit got;
      got = 1'b0;
      for (int i = 0; i < 30 && !got; i++) begin
         @(negedge clk);
         #1;
         got = hs0 || hs1;
      end
      if (!got) chk("handshake_timeout", 64'd0, 64'd1);
   endtask

   task automatic put(input bit w, input logic [31:0] a, input logic [31:0] b, input logic c);
      @(posedge clk);
      #1;
      if (w) begin
         req1_valid = 1'b1; req1_a = a; req1_b = b; req1_cin = c;
      end else begin
         req0_valid = 1'b1; req0_a = a; req0_b = b; req0_cin = c;
      end
      wait_hs();
      @(posedge clk);
      #1;
      if (w) req1_valid = 1'b0;
      else   req0_valid = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0;
      req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_cin = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_cin = 1'b0;
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      wait_hs();
      @(posedge clk);
      #1 req0_valid = 1'b0;

      put(1'b1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);

      @(posedge clk);
      #1;
      req0_valid = 1'b1; req0_a = 32'd5;   req0_b = 32'd6;   req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd100; req1_b = 32'd200; req1_cin = 1'b1;
      repeat (10) @(posedge clk);
      #1 req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) @(posedge clk);

      #1 res_ready = 1'b0;
      put(1'b0, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
      req0_valid = 1'b1; req0_a = 32'd3; req0_b = 32'd4; req0_cin = 1'b1;
      repeat (6) @(posedge clk);
      #1 res_ready = 1'b1;
      wait_hs();
      @(posedge clk);
      #1 req0_valid = 1'b0;
      repeat (3) @(posedge clk);

      put(1'b0, 32'd10, 32'd20, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      req0_valid = 1'b1; req0_a = 32'h8000_0000; req0_b = 32'h8000_0000; req0_cin = 1'b0;
      req1_valid = 1'b1; req1_a = 32'd9;         req1_b = 32'd9;         req1_cin = 1'b0;
      wait_hs();
      @(posedge clk);
      #1 req0_valid = 1'b0; req1_valid = 1'b0;

      for (int k = 0; k < 2000; k++) begin
         @(posedge clk);
         #1;
         if (!req0_valid || hs0) begin
            req0_valid = $urandom_range(0, 2) != 0;
            req0_a = rnd(); req0_b = rnd(); req0_cin = 1'($urandom_range(0, 1));
         end
         if (!req1_valid || hs1) begin
            req1_valid = $urandom_range(0, 2) != 0;
            req1_a = rnd(); req1_b = rnd(); req1_cin = 1'($urandom_range(0, 1));
         end
         res_ready = $urandom_range(0, 3) != 0;
      end

      @(posedge clk);
      #1 req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
      chk("fixprio_progress", 64'(fx_n >= 100), 64'd1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/csa_arbiter.md
CSA_ARBITER -- requirements
Module: csa_arbiter

Interface
REQ-001 Parameter: PRIO_FIX, default 0; 0 = round-robin grant, 1 = fixed priority with requester 0 always winning.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Ports: req0_valid / req1_valid  input  1  requester has operands pending.
REQ-005 Ports: req0_ready / req1_ready  output  1  operands accepted this cycle; a transfer occurs when valid and ready are both 1.
REQ-006 Ports: req0_a, req0_b, req1_a, req1_b  input  32  operands; req0_cin / req1_cin  input  1  carry-in.
REQ-007 Ports: res_valid  output  1; res_ready  input  1; res_sum  output  32; res_cout  output  1; res_id  output  1 (index of the granted requester).
REQ-008 Port: res_ovf  output  1  signed overflow; present only when CSA_ARB_OVF_EN is defined.

Function
REQ-009 Block SHALL own one instance of the team's 32-bit carry-select adder and share it between two requesters.
REQ-010 FSM states SHALL be IDLE, CALC and RESULT.
REQ-011 IDLE: when any valid is 1, the block SHALL assert the winner's ready combinationally, register its a/b/cin/id and go to CALC; otherwise it SHALL stay in IDLE.
REQ-012 The loser's ready SHALL be 0; at most one ready SHALL be 1 in any cycle.
REQ-013 CALC: the adder SHALL operate on the registered operands; sum/cout SHALL be registered into res_* and the FSM SHALL go to RESULT; lasts exactly 1 cycle.
REQ-014 RESULT: res_valid SHALL be 1 and res_sum/res_cout/res_id SHALL hold stable until res_ready=1.
REQ-015 RESULT with res_ready=1 and any request valid: the block SHALL accept the new winner in the same cycle and go to CALC (back-to-back); with no request valid it SHALL go to IDLE.
REQ-016 Latency: accept at cycle N gives res_valid=1 at cycle N+2; peak throughput is one result per 2 cycles.
REQ-017 Round-robin (PRIO_FIX=0): when both requesters are valid, the requester not granted last SHALL win; a lone valid requester SHALL always win.
REQ-018 The last-grant pointer SHALL update only on an accepted transfer.
REQ-019 Ready SHALL be 0 in CALC and in RESULT without res_ready; valid held by a requester is not consumed.
REQ-020 Arithmetic: res_sum = (a + b + cin) mod 2^32; res_cout = bit 32 of the full sum.
REQ-021 In IDLE and CALC, res_valid SHALL be 0.

Reset
REQ-022 rst_n=0 SHALL immediately force: state IDLE, res_valid 0, res_sum 0, res_cout 0, res_id 0, res_ovf 0, both readys 0, last-grant pointer = 1 (so requester 0 wins the first tie).
REQ-023 Reset asserted in CALC or RESULT SHALL discard the in-flight operation; no result is delivered after release.
REQ-024 The first acceptance SHALL occur no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-025 Macro CSA_ARB_OVF_EN defined: the port res_ovf SHALL exist; it is registered in CALC as (a[31]==b[31]) && (sum[31]!=a[31]) and has the same timing as res_sum.
REQ-026 Macro CSA_ARB_OVF_EN undefined: the port res_ovf and its logic SHALL be absent; all other behaviour is unchanged.

Verification
REQ-027 Reset, then req0 a=0x0000_0001, b=0x0000_0002, cin=0 -> req0_ready=1 at cycle 0; res_valid=1 at cycle 2 with sum=0x0000_0003, cout=0, id=0.
REQ-028 req1 a=0xFFFF_FFFF, b=0x0000_0000, cin=1 -> sum=0x0000_0000, cout=1, id=1; with OVF_EN, ovf=0.
REQ-029 Both requesters valid continuously, res_ready=1 (PRIO_FIX=0) -> grants 0,1,0,1; one result every 2 cycles; with PRIO_FIX=1 -> grants are all 0.
REQ-030 res_ready held 0 for 5 cycles in RESULT -> res_* stable, both readys 0; res_ready=1 with req0 valid -> accept in the same cycle.
REQ-031 With OVF_EN, a=0x7FFF_FFFF, b=0x0000_0001 -> sum=0x8000_0000, ovf=1, cout=0.
REQ-032 rst_n pulsed low during CALC -> res_valid stays 0 and all outputs read 0; a new request afterward completes normally with requester 0 winning a tie.
